sn74xx251_rx: RTL and testbench

- Receiving end of a scanned 8:1 mux link (SN74XX251 driven by a 3-bit select counter plus strobe).
- Samples the serial bit `din` at bit position `sel` while the strobe is active, and reassembles full 8-bit words.
- Presents each completed word on a valid/ready output with overflow and frame-error reporting.
- Used to rebuild parallel data scanned through a single 251 output line.

---
 rtl/sn74xx251_rx.sv | 122 ++++++++++++
 tb/tb_sn74xx251_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sn74xx251_rx.sv
// Rebuilds 8-bit words from a scanned SN74XX251 line (din at index sel while _str=0); optional macro SN74XX251_RX_DIFF_CHECK_EN adds a _din complement check.
// Latency: q_valid rises in the cycle right after the edge that samples the last missing bit.
// Backpressure: q holds while q_valid && !q_ready; a word completing then is dropped and ovf sticks until clr/_rst.
module sn74xx251_rx #(
  parameter int         SEQ_CHECK = 1,
  parameter logic [7:0] INIT_Q    = 8'h00
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       din,
`ifdef SN74XX251_RX_DIFF_CHECK_EN
  input  logic       _din,
`endif
  input  logic [2:0] sel,
  input  logic       _str,
  input  logic       clr,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic       q_ready,
  output logic       busy,
  output logic       ferr,
  output logic       ovf
);

  logic [7:0] asm_q, asm_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] exp_q, exp_d;
  logic [7:0] q_d;
  logic       q_valid_d, ferr_d, ovf_d;
  logic       sample_ok, take, done;

`ifdef SN74XX251_RX_DIFF_CHECK_EN
  // Equal or unknown rails both fail: the xor must resolve to a definite 1.
  assign sample_ok = ((din ^ _din) === 1'b1);
`else
  assign sample_ok = 1'b1;
`endif

  always_comb begin
    asm_d     = asm_q;
    mask_d    = mask_q;
    exp_d     = exp_q;
    q_d       = q;
    q_valid_d = q_valid;
    ferr_d    = 1'b0;
    ovf_d     = ovf;
    take      = 1'b0;
    done      = 1'b0;

    if (!_str) begin
      if (!sample_ok) begin
        ferr_d = 1'b1;
        mask_d = 8'h00;
        exp_d  = 3'd0;
      end else if (SEQ_CHECK == 0 || sel == exp_q) begin
        take        = 1'b1;
        asm_d[sel]  = din;
        mask_d[sel] = 1'b1;
        if (SEQ_CHECK != 0) exp_d = exp_q + 3'd1;
      end else begin
        // Out-of-order index: a sel of 0 is still a legal word start.
        ferr_d = 1'b1;
        mask_d = 8'h00;
        exp_d  = 3'd0;
        if (sel == 3'd0) begin
          take     = 1'b1;
          asm_d[0] = din;
          mask_d   = 8'h01;
          exp_d    = 3'd1;
        end
      end
    end

    done = take && (mask_d == 8'hFF);
    if (done) begin
      mask_d = 8'h00;
      exp_d  = 3'd0;
    end

    if (done) begin
      if (!q_valid || q_ready) begin
        q_d       = asm_d;
        q_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (q_valid && q_ready) begin
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      asm_q   <= 8'h00;
      mask_q  <= 8'h00;
      exp_q   <= 3'd0;
      q       <= INIT_Q;
      q_valid <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (clr) begin
      asm_q   <= 8'h00;
      mask_q  <= 8'h00;
      exp_q   <= 3'd0;
      q       <= INIT_Q;
      q_valid <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      mask_q  <= mask_d;
      exp_q   <= exp_d;
      q       <= q_d;
      q_valid <= q_valid_d;
      ferr    <= ferr_d;
      ovf     <= ovf_d;
    end
  end

  assign busy = (mask_q != 8'h00);

endmodule

// File: tb/tb_sn74xx251_rx.sv
// Directed bench for sn74xx251_rx (default SEQ_CHECK=1, INIT_Q=8'h00).
module tb_sn74xx251_rx;

  logic       clk;
  logic       _rst;
  logic       din;
  logic [2:0] sel;
  logic       _str;
  logic       clr;
  logic [7:0] q;
  logic       q_valid;
  logic       q_ready;
  logic       busy;
  logic       ferr;
  logic       ovf;

  int checks = 0;
  int errors = 0;

`ifdef SN74XX251_RX_DIFF_CHECK_EN
  logic dbad = 1'b0;
  logic _din;
  assign _din = ~din ^ dbad;
`endif

  sn74xx251_rx dut (
    .clk     (clk),
    ._rst    (_rst),
    .din     (din),
`ifdef SN74XX251_RX_DIFF_CHECK_EN
    ._din    (_din),
`endif
    .sel     (sel),
    ._str    (_str),
    .clr     (clr),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .busy    (busy),
    .ferr    (ferr),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input logic [2:0] s, input logic d);
    sel  = s;
    din  = d;
    _str = 1'b0;
    tick();
    _str = 1'b1;
  endtask

  task automatic scan(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      sample(3'(i), w[i]);
      if (i == 3) chk("busy_mid_scan", {7'd0, busy}, 8'd1);
    end
  endtask

  initial begin
    _rst = 1'b0; din = 1'b0; sel = 3'd0; _str = 1'b1; clr = 1'b0; q_ready = 1'b1;
    #2;
    chk("rst_q", q, 8'h00);
    chk("rst_q_valid", {7'd0, q_valid}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ferr", {7'd0, ferr}, 8'd0);
    chk("rst_ovf", {7'd0, ovf}, 8'd0);
    #10 _rst = 1'b1;

    // 1: basic word with consumer ready
    scan(8'hA5);
    chk("t1_q", q, 8'hA5);
    chk("t1_q_valid", {7'd0, q_valid}, 8'd1);
    chk("t1_busy_after", {7'd0, busy}, 8'd0);
    chk("t1_ovf", {7'd0, ovf}, 8'd0);
    chk("t1_ferr", {7'd0, ferr}, 8'd0);
    tick();
    chk("t1_q_valid_pulse", {7'd0, q_valid}, 8'd0);

    // 2: backpressure and overflow
    q_ready = 1'b0;
    scan(8'hA5);
    chk("t2_first_q", q, 8'hA5);
    scan(8'h3C);
    chk("t2_q_held", q, 8'hA5);
    chk("t2_q_valid", {7'd0, q_valid}, 8'd1);
    chk("t2_ovf_set", {7'd0, ovf}, 8'd1);
    q_ready = 1'b1;
    tick();
    chk("t2_q_valid_drained", {7'd0, q_valid}, 8'd0);
    chk("t2_ovf_sticky", {7'd0, ovf}, 8'd1);
    chk("t2_q_after_drain", q, 8'hA5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t2_clr_ovf", {7'd0, ovf}, 8'd0);
    chk("t2_clr_q", q, 8'h00);

    // 3: strobe gap mid-word
    sample(3'd0, 1'b0); sample(3'd1, 1'b1); sample(3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_gap_ferr", {7'd0, ferr}, 8'd0);
      chk("t3_gap_busy", {7'd0, busy}, 8'd1);
    end
    sample(3'd3, 1'b1); sample(3'd4, 1'b1); sample(3'd5, 1'b0);
    sample(3'd6, 1'b1); sample(3'd7, 1'b0);
    chk("t3_q", q, 8'h5A);
    chk("t3_q_valid", {7'd0, q_valid}, 8'd1);
    tick();

    // 4: ordering error, then recovery
    sample(3'd0, 1'b1); sample(3'd1, 1'b1); sample(3'd3, 1'b1);
    chk("t4_ferr_pulse", {7'd0, ferr}, 8'd1);
    chk("t4_busy_cleared", {7'd0, busy}, 8'd0);
    tick();
    chk("t4_ferr_one_cycle", {7'd0, ferr}, 8'd0);
    scan(8'hFF);
    chk("t4_q", q, 8'hFF);
    chk("t4_q_valid", {7'd0, q_valid}, 8'd1);
    tick();

    // 5: back-to-back words
    scan(8'h01);
    chk("t5_q_first", q, 8'h01);
    chk("t5_q_valid_first", {7'd0, q_valid}, 8'd1);
    sample(3'd0, 1'b0);
    chk("t5_q_valid_gap", {7'd0, q_valid}, 8'd0);
    for (int i = 1; i < 8; i++) sample(3'(i), (i == 7));
    chk("t5_q_second", q, 8'h80);
    chk("t5_q_valid_second", {7'd0, q_valid}, 8'd1);
    chk("t5_ovf", {7'd0, ovf}, 8'd0);
    tick();

    // 6: asynchronous reset mid-word with a held word pending
    q_ready = 1'b0;
    scan(8'hC3);
    for (int i = 0; i < 5; i++) sample(3'(i), 1'b1);
    chk("t6_busy_pre", {7'd0, busy}, 8'd1);
    chk("t6_q_pre", q, 8'hC3);
    #2 _rst = 1'b0;
    #1;
    chk("t6_rst_q", q, 8'h00);
    chk("t6_rst_q_valid", {7'd0, q_valid}, 8'd0);
    chk("t6_rst_busy", {7'd0, busy}, 8'd0);
    chk("t6_rst_ferr", {7'd0, ferr}, 8'd0);
    #1 _rst = 1'b1;
    q_ready = 1'b1;
    scan(8'h96);
    chk("t6_after_q", q, 8'h96);
    chk("t6_after_q_valid", {7'd0, q_valid}, 8'd1);
    tick();

`ifdef SN74XX251_RX_DIFF_CHECK_EN
    sample(3'd0, 1'b1); sample(3'd1, 1'b0);
    dbad = 1'b1;
    sample(3'd2, 1'b1);
    dbad = 1'b0;
    chk("t6_diff_ferr", {7'd0, ferr}, 8'd1);
    chk("t6_diff_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("t6_diff_ferr_clear", {7'd0, ferr}, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
